// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } seq_state_t;

  typedef logic [1:0] rst_cause_t;

  localparam rst_cause_t CAUSE_NONE = 2'b00;
  localparam rst_cause_t CAUSE_PIN  = 2'b01;
  localparam rst_cause_t CAUSE_SOFT = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Negedge deassertion synchronizer for RST_n; assertion stays asynchronous.
module rst_seq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic RST_n,
  output logic sync_ok
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_ok = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: hold, then release N_DOMAINS resets in index order on falling edges.
// Optional last-cause register enabled by defining RST_SEQ_CAUSE_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 8,
  parameter int unsigned N_DOMAINS   = 3
) (
  input  logic                 clk,
  input  logic                 RST_n,
  input  logic                 soft_rst_req,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 seq_done
`ifdef RST_SEQ_CAUSE_EN
  ,
  output rst_cause_t           rst_cause
`endif
);

  localparam int unsigned CntW = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
  localparam int unsigned IdxW = $clog2(N_DOMAINS + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(N_DOMAINS - 1);
  localparam logic            SingleDomain = (N_DOMAINS == 1);

  logic sync_ok;

  seq_state_t           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [N_DOMAINS-1:0] out_q, out_d;
  logic                 done_q, done_d;

  rst_seq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .RST_n  (RST_n),
    .sync_ok(sync_ok)
  );

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // Terminal count fires on the edge where the counter would reach its limit,
  // so the release lands on the same edge the count completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;
    if (soft_rst_req) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (sync_ok) begin
            if (cnt_q == HoldLast) begin
              out_d[0] = 1'b1;
              cnt_d    = '0;
              idx_d    = IdxW'(1);
              done_d   = SingleDomain;
              state_d  = SingleDomain ? DONE : RELEASE;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        RELEASE: begin
          if (cnt_q == GapLast) begin
            cnt_d = '0;
            for (int i = 0; i < int'(N_DOMAINS); i++) begin
              if (IdxW'(i) == idx_q) out_d[i] = 1'b1;
            end
            if (idx_q == IdxLast) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DONE: ;
        default: state_d = HOLD;
      endcase
    end
  end

  assign rst_n_out = out_q;
  assign seq_done  = done_q;

`ifdef RST_SEQ_CAUSE_EN
  logic       sync_ok_q;
  rst_cause_t cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (soft_rst_req) begin
      cause_d = CAUSE_SOFT;
    end else if (sync_ok && !sync_ok_q) begin
      cause_d = CAUSE_PIN;
    end
  end

  always_ff @(negedge clk or negedge RST_n) begin
    if (!RST_n) begin
      sync_ok_q <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      sync_ok_q <= sync_ok;
      cause_q   <= cause_d;
    end
  end

  assign rst_cause = cause_q;
`endif

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq (default build plus a single-domain instance).
module tb_rst_seq;

  logic       clk;
  logic       RST_n;
  logic       soft_rst_req;
  logic       soft1;
  logic [2:0] rst_n_out;
  logic       seq_done;
  logic [0:0] rst_n_out1;
  logic       seq_done1;
`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] rst_cause;
  logic [1:0] rst_cause1;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int neg_n    = 0;

  rst_seq u_dut (
    .clk         (clk),
    .RST_n       (RST_n),
    .soft_rst_req(soft_rst_req),
    .rst_n_out   (rst_n_out),
    .seq_done    (seq_done)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .rst_cause   (rst_cause)
`endif
  );

  rst_seq #(
    .SYNC_STAGES(2),
    .HOLD_CYCLES(1),
    .GAP_CYCLES (8),
    .N_DOMAINS  (1)
  ) u_dut1 (
    .clk         (clk),
    .RST_n       (RST_n),
    .soft_rst_req(soft1),
    .rst_n_out   (rst_n_out1),
    .seq_done    (seq_done1)
`ifdef RST_SEQ_CAUSE_EN
    ,
    .rst_cause   (rst_cause1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (negedge %0d)", tag, obs, exp, neg_n);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] exp_out, input logic exp_done);
    chk({tag, " out"}, {5'd0, rst_n_out}, {5'd0, exp_out});
    chk({tag, " done"}, {7'd0, seq_done}, {7'd0, exp_done});
  endtask

  task automatic chk_cause(input string tag, input logic [1:0] exp);
`ifdef RST_SEQ_CAUSE_EN
    chk({tag, " cause"}, {6'd0, rst_cause}, {6'd0, exp});
`else
    if (exp == 2'b11) $display("reserved cause value requested at %s", tag);
`endif
  endtask

  // Advance to negedge n (counted since the last RST_n release), then sample 1ns later.
  task automatic step_to(input int n);
    while (neg_n < n) begin
      @(negedge clk);
      neg_n++;
    end
    #1;
  endtask

  initial begin
    RST_n        = 1'b0;
    soft_rst_req = 1'b0;
    soft1        = 1'b0;
    #3;
    chk_out("reset", 3'b000, 1'b0);
    chk_cause("reset", 2'b00);
    repeat (3) @(negedge clk);
    #2;
    RST_n = 1'b1;
    neg_n = 0;

    // Power-up sequence; single-domain instance releases on negedge 3
    step_to(2);
    chk("t5 n2 out", {7'd0, rst_n_out1}, 8'd0);
    chk("t5 n2 done", {7'd0, seq_done1}, 8'd0);
    step_to(3);
    chk("t5 n3 out", {7'd0, rst_n_out1}, 8'd1);
    chk("t5 n3 done", {7'd0, seq_done1}, 8'd1);
    chk_cause("t6 pin", 2'b01);
    step_to(17); chk_out("t1 n17", 3'b000, 1'b0);
    step_to(18); chk_out("t1 n18", 3'b001, 1'b0);
    step_to(25); chk_out("t1 n25", 3'b001, 1'b0);
    step_to(26); chk_out("t1 n26", 3'b011, 1'b0);
    step_to(30); chk_out("t2 n30", 3'b011, 1'b0);

    // Async pulse between edges
    #2;
    RST_n = 1'b0;
    #1;
    chk_out("t2 async", 3'b000, 1'b0);
    chk_cause("t2 async", 2'b00);
    RST_n = 1'b1;
    neg_n = 0;
    step_to(17); chk_out("t2 n17", 3'b000, 1'b0);
    step_to(18); chk_out("t2 n18", 3'b001, 1'b0);
    step_to(26); chk_out("t2 n26", 3'b011, 1'b0);
    step_to(33); chk_out("t2 n33", 3'b011, 1'b0);
    step_to(34); chk_out("t2 n34", 3'b111, 1'b1);
    chk_cause("t6 pin2", 2'b01);

    // One-cycle soft request in DONE
    step_to(35);
    soft_rst_req = 1'b1;
    step_to(36);
    chk_out("t3 req", 3'b000, 1'b0);
    chk_cause("t3 soft", 2'b10);
    soft_rst_req = 1'b0;
    step_to(51); chk_out("t3 n51", 3'b000, 1'b0);
    step_to(52); chk_out("t3 n52", 3'b001, 1'b0);
    step_to(59); chk_out("t3 n59", 3'b001, 1'b0);
    step_to(60); chk_out("t3 n60", 3'b011, 1'b0);
    step_to(68); chk_out("t3 n68", 3'b111, 1'b1);
    chk_cause("t3 after", 2'b10);

    // Soft request held 40 cycles
    soft_rst_req = 1'b1;
    step_to(69);  chk_out("t4 n69", 3'b000, 1'b0);
    step_to(108); chk_out("t4 n108", 3'b000, 1'b0);
    soft_rst_req = 1'b0;
    step_to(123); chk_out("t4 n123", 3'b000, 1'b0);
    step_to(124); chk_out("t4 n124", 3'b001, 1'b0);

    // Soft request landing on the hold terminal-count edge
    soft_rst_req = 1'b1;
    step_to(125); chk_out("t4 n125", 3'b000, 1'b0);
    soft_rst_req = 1'b0;
    step_to(140);
    soft_rst_req = 1'b1;
    step_to(141); chk_out("t4 tc", 3'b000, 1'b0);
    soft_rst_req = 1'b0;
    step_to(156); chk_out("t4 n156", 3'b000, 1'b0);
    step_to(157); chk_out("t4 n157", 3'b001, 1'b0);
    step_to(165); chk_out("t4 n165", 3'b011, 1'b0);
    step_to(173); chk_out("t4 n173", 3'b111, 1'b1);

    // Pin reset after a soft sequence restores the pin cause
    #2;
    RST_n = 1'b0;
    #1;
    chk_out("t6 rst", 3'b000, 1'b0);
    chk_cause("t6 rst", 2'b00);
    RST_n = 1'b1;
    neg_n = 0;
    step_to(3);  chk_cause("t6 pin3", 2'b01);
    step_to(18); chk_out("t6 n18", 3'b001, 1'b0);
    step_to(34); chk_out("t6 n34", 3'b111, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Reset sequencer downstream of the raw push-button/POR reset.
- Synchronizes the asynchronous RST_n.
- Holds all subsystem resets for a programmable interval, then releases N_DOMAINS subsystem resets one at a time, in index order, with a fixed gap between releases.
- Supports a synchronous soft-reset request that re-runs the whole sequence.
- All sequential logic runs on negedge clk, so every reset deasserts on a falling edge.

Parameters:
- SYNC_STAGES, 2: flop stages in the RST_n deassertion synchronizer; legal range 2..4.
- HOLD_CYCLES, 16: negedges counted after the synchronizer releases, before domain 0 deasserts; must be >= 1.
- GAP_CYCLES, 8: negedges between consecutive domain releases; must be >= 1.
- N_DOMAINS, 3: number of sequenced reset outputs; legal range 1..8.

Ports:
- clk, input, 1: system clock; all flops on negedge.
- RST_n, input, 1: reset, asynchronous, active-low.
- soft_rst_req, input, 1: synchronous to clk, level-sensitive; high requests re-sequencing.
- rst_n_out, output, N_DOMAINS: per-domain active-low resets; bit 0 releases first.
- seq_done, output, 1: high once all domains are released.
- rst_cause, output, 2: last reset cause; present only with RST_SEQ_CAUSE_EN.

Behaviour:
- RST_n low, asynchronous, no clock needed:
  - synchronizer chain = 0, state = HOLD, counter = 0.
  - rst_n_out = all 0, seq_done = 0.
- Synchronizer: chain of SYNC_STAGES flops, async-cleared, D of first stage = 1. Output sync_ok rises on the SYNC_STAGES-th negedge after RST_n rises.
- FSM (states in package enum): HOLD, RELEASE, DONE.
- HOLD:
  - counter increments each negedge while sync_ok = 1 and soft_rst_req = 0.
  - When counter reaches HOLD_CYCLES: rst_n_out[0] = 1 on that same edge, counter cleared, idx = 1.
  - Next state is RELEASE, or DONE if N_DOMAINS = 1.
- RELEASE:
  - counter counts to GAP_CYCLES; on that edge rst_n_out[idx] = 1, idx++, counter cleared.
  - When the final bit N_DOMAINS-1 sets: seq_done = 1 on the same edge and state goes to DONE.
- DONE: hold all outputs high until a soft request or RST_n.
- Released outputs stay high; bits release strictly in index order, never simultaneously.
- Timing with defaults, numbering the first negedge after RST_n rises as negedge 1:
  - rst_n_out[0] rises on negedge 18, [1] on 26, [2] on 34.
  - seq_done rises on negedge 34.
  - General form: SYNC_STAGES + HOLD_CYCLES + i*GAP_CYCLES.
- soft_rst_req = 1 sampled at a negedge, in any state:
  - on that edge rst_n_out = all 0, seq_done = 0, counter = 0, state = HOLD. This assertion is synchronous.
  - While the request stays high, the block remains in HOLD with counter held at 0.
  - Counting restarts on the first negedge with the request low. Release timing then matches power-up minus the SYNC_STAGES term.
  - The synchronizer is unaffected.
- RST_n asserted mid-sequence: immediate async clear of everything, and the full sequence restarts on deassertion.
- Simultaneous events: RST_n low dominates soft_rst_req; soft_rst_req dominates any counter terminal count on the same edge.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1); it never wraps, because it is cleared at terminal count.
- idx width: $clog2(N_DOMAINS + 1).

Optional Feature:
RST_SEQ_CAUSE_EN
- Defined: 2-bit rst_cause register, updated on negedge only:
  - 2'b01 after an RST_n-initiated sequence, captured when sync_ok rises.
  - 2'b10 when soft_rst_req initiates a sequence.
  - Async reset value 2'b00. The 2'b01 write happens after reset release, so the value survives until the next event.
  - Values: 00 = no sequence since power-up, 11 = reserved.
- Undefined: rst_cause port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package rst_seq_pkg:
  - typedef enum logic [1:0] seq_state_t {HOLD, RELEASE, DONE}.
  - typedef logic [1:0] rst_cause_t, with localparams CAUSE_NONE = 2'b00, CAUSE_PIN = 2'b01, CAUSE_SOFT = 2'b10.
- Sub-module rst_seq_sync: parameterized SYNC_STAGES negedge chain with async clear, output sync_ok. The FSM, counter and outputs live in rst_seq.

Test Plan:
1. Defaults, RST_n held low then released before a falling edge -> rst_n_out goes 000 to 001 at negedge 18, 011 at 26, 111 at 34; seq_done rises at 34.
2. RST_n pulsed low between clock edges at negedge 30 (rst_n_out = 011) -> outputs are 000 immediately, without a clock edge; re-release gives the test 1 timing.
3. In DONE, soft_rst_req high for 1 cycle -> rst_n_out = 000 and seq_done = 0 on the sampling edge; 001 follows 16 negedges after the request falls, then 011 and 111 at 8-negedge gaps.
4. soft_rst_req held high for 40 cycles during HOLD -> no release while high; release timing counts only from the request's fall. Also assert soft_rst_req on the exact HOLD terminal-count edge -> no release occurs.
5. N_DOMAINS = 1, HOLD_CYCLES = 1, SYNC_STAGES = 2 -> rst_n_out[0] and seq_done both rise on negedge 3.
6. With RST_SEQ_CAUSE_EN -> rst_cause = 00 in reset, 01 after pin release (test 1), 10 after test 3, back to 01 after the next RST_n cycle.
